ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU in the MIPS core; registers ALU result/zero plus the EX-stage control and store data, and presents them to the MEM stage.
- Valid/ready handshake with a 2-entry skid buffer, so MEM backpressure never creates a combinational path to EX.
- Resolves conditional branches from the ALU zero flag, supports synchronous flush, and counts backpressure cycles.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_W, 5, width of destination register index.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EX presents a valid entry.
- in_ready  out  1  stage can accept an entry.
- in_result  in  DATA_W  ALU result.
- in_zero  in  1  ALU zero flag.
- in_store_data  in  DATA_W  rt operand for stores.
- in_dest  in  REG_W  destination register index.
- in_ctrl  in  4  {reg_write, mem_read, mem_write, branch}, MSB first.
- in_bne  in  1  1 = branch on not-equal, 0 = branch on equal.
- flush  in  1  synchronous kill of all held and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM accepts head entry.
- out_result, out_store_data, out_dest, out_ctrl  out  registered copies of the head entry fields.
- out_branch_taken  out  1  head entry is a taken branch.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main register M (drives out_*), skid register S, each with its own valid bit (m_v, s_v).
- Reset (rst_n=0, asynchronous): m_v=0, s_v=0, out_valid=0, in_ready=1, out_branch_taken=0, stall_cnt=0; all data/ctrl outputs 0.
- in_ready = ~s_v, taken directly from a flop; no combinational dependence on out_ready.
- Accept = in_valid & in_ready. Drain = m_v & out_ready.
- At capture, taken = in_ctrl[0] & (in_zero ^ in_bne) is stored with the entry. out_branch_taken = m_v & stored taken.
- Per edge, with flush=0:
  - m_v=0: an accepted entry goes into M.
  - m_v=1 & drain: M loads S if s_v, else the accepted entry, else m_v clears. s_v clears when S moves to M.
  - m_v=1 & ~drain & accept: the entry goes into S and s_v is set.
  - m_v=1 & ~drain & ~accept: hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Full throughput (1 entry/cycle) while out_ready=1.
- Ordering: strictly FIFO. S never overtakes M.
- Full (s_v=1): in_ready=0. in_valid is ignored and EX must hold its entry.
- flush=1: at the next edge m_v=0 and s_v=0. Any entry accepted in the same cycle is dropped. A drain in that cycle still counts as consumed by MEM. in_ready is unaffected by flush in the flush cycle.
- stall_cnt: increments when out_valid & ~out_ready, saturates at 2^CNT_W-1, never wraps. Flush does not clear it; only reset does.
- Data fields of invalid entries are don't-care, except after reset, when they are 0.
- Reset asserted mid-transfer: all entries are lost and outputs return to reset values immediately. There is no recovery of in-flight data.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, in_ready=1, stall_cnt=0, out_result=0. Release -> same until first accept.
- Streaming: out_ready=1, send results 0x1, 0x2, 0x3 on consecutive cycles -> appear one cycle later, in order, no bubbles, in_ready stays 1.
- Backpressure: out_ready=0, send 0xA then 0xB -> out_result=0xA, S holds 0xB, in_ready=0; 0xC held by EX. Raise out_ready -> 0xA, 0xB, 0xC delivered in order, stall_cnt equals the stalled cycle count.
- Branch: branch=1, bne=0, zero=1 -> out_branch_taken=1. Then bne=1, zero=1 -> 0. Then branch=0, zero=1 -> 0.
- Flush: both registers full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle entry is never output.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15. Assert rst_n=0 mid-stall -> stall_cnt=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer: 1-cycle latency, full throughput.
// in_ready comes straight from the skid-valid flop, so MEM backpressure never reaches EX combinationally.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [3:0]        in_ctrl,
  input  logic              in_bne,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_dest,
  output logic [3:0]        out_ctrl,
  output logic              out_branch_taken,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest;
    logic [3:0]        ctrl;
    logic              taken;
  } entry_t;

  entry_t m_q, s_q, in_e;
  logic   m_v, s_v;
  logic   accept, drain;

  // Branch outcome is resolved once, at capture, and travels with the entry.
  always_comb begin
    in_e            = '0;
    in_e.result     = in_result;
    in_e.store_data = in_store_data;
    in_e.dest       = in_dest;
    in_e.ctrl       = in_ctrl;
    in_e.taken      = in_ctrl[0] & (in_zero ^ in_bne);
  end

  assign in_ready = ~s_v;
  assign accept   = in_valid & ~s_v;
  assign drain    = m_v & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v       <= 1'b0;
      s_v       <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
      stall_cnt <= '0;
    end else begin
      if (m_v && !out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
      end else if (!m_v) begin
        m_v <= accept;
        if (accept) m_q <= in_e;
      end else if (drain) begin
        // s_v implies in_ready=0, so the skid and an accept never compete for M.
        if (s_v) begin
          m_q <= s_q;
          s_v <= 1'b0;
        end else if (accept) begin
          m_q <= in_e;
        end else begin
          m_v <= 1'b0;
        end
      end else if (accept) begin
        s_q <= in_e;
        s_v <= 1'b1;
      end
    end
  end

  assign out_valid        = m_v;
  assign out_result       = m_q.result;
  assign out_store_data   = m_q.store_data;
  assign out_dest         = m_q.dest;
  assign out_ctrl         = m_q.ctrl;
  assign out_branch_taken = m_v & m_q.taken;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage, checked against a queue-based model of a 2-deep FIFO stage.
module tb_ex_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_zero, in_bne, flush;
  logic [DW-1:0] in_result, in_store_data;
  logic [RW-1:0] in_dest;
  logic [3:0]    in_ctrl;
  logic          out_valid, out_ready, out_branch_taken;
  logic [DW-1:0] out_result, out_store_data;
  logic [RW-1:0] out_dest;
  logic [3:0]    out_ctrl;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_store_data(in_store_data),
    .in_dest(in_dest), .in_ctrl(in_ctrl), .in_bne(in_bne), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_dest(out_dest), .out_ctrl(out_ctrl),
    .out_branch_taken(out_branch_taken), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [DW-1:0] sd;
    logic [RW-1:0] dest;
    logic [3:0]    ctrl;
    bit            tk;
  } ent_t;

  ent_t        q[$];
  int unsigned m_stall = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (q.size() > 0) begin
      chk("out_result", 64'(out_result), 64'(q[0].res));
      chk("out_store_data", 64'(out_store_data), 64'(q[0].sd));
      chk("out_dest", 64'(out_dest), 64'(q[0].dest));
      chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
      chk("out_branch_taken", 64'(out_branch_taken), 64'(q[0].tk));
    end else begin
      chk("taken_idle", 64'(out_branch_taken), 64'd0);
    end
  endtask

  // Check at the falling edge, then advance the model across the next rising edge.
  task automatic cycle();
    ent_t e;
    bit   acc, drn, fl;
    @(negedge clk);
    compare();
    acc    = in_valid && q.size() < 2;
    drn    = q.size() > 0 && out_ready;
    fl     = flush;
    e.res  = in_result;
    e.sd   = in_store_data;
    e.dest = in_dest;
    e.ctrl = in_ctrl;
    e.tk   = in_ctrl[0] && (in_zero != in_bne);
    if (q.size() > 0 && !out_ready && m_stall < SAT) m_stall++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic set_in(input bit v, input logic [DW-1:0] res, input logic [3:0] ctrl,
                        input bit z, input bit bne);
    in_valid      = v;
    in_result     = res;
    in_ctrl       = ctrl;
    in_zero       = z;
    in_bne        = bne;
    in_store_data = $urandom;
    in_dest       = RW'($urandom);
  endtask

  task automatic rand_in();
    set_in(($urandom_range(0, 9) < 7), $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
    out_ready = ($urandom_range(0, 9) < 6);
    flush     = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    bit will_acc;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0);

    // Reset held with random inputs toggling.
    for (int i = 0; i < 3; i++) begin
      rand_in();
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      @(posedge clk);
      #1;
    end
    set_in(0, 0, 0, 0, 0);
    flush = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    cycle();
    chk("post_rst_out_result", 64'(out_result), 64'd0);
    cycle();

    // Streaming at full rate.
    for (int i = 1; i <= 3; i++) begin
      set_in(1, DW'(i), 4'b1000, 0, 0);
      cycle();
    end
    set_in(0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Backpressure: A in M, B in skid, C held by EX.
    out_ready = 1'b0;
    set_in(1, 32'hA, 4'b1000, 0, 0);
    cycle();
    set_in(1, 32'hB, 4'b1000, 0, 0);
    cycle();
    set_in(1, 32'hC, 4'b1000, 0, 0);
    repeat (3) cycle();
    chk("bp_skid_full", 64'(in_ready), 64'd0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      will_acc = q.size() < 2;
      cycle();
      if (will_acc) break;
    end
    set_in(0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Branch resolution.
    set_in(1, 32'h10, 4'b0001, 1, 0);
    cycle();
    set_in(1, 32'h11, 4'b0001, 1, 1);
    cycle();
    set_in(1, 32'h12, 4'b0000, 1, 0);
    cycle();
    set_in(1, 32'h13, 4'b0001, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 0);
    repeat (2) cycle();

    // Flush with both registers full and a new entry offered.
    out_ready = 1'b0;
    set_in(1, 32'h21, 4'b1000, 0, 0);
    cycle();
    set_in(1, 32'h22, 4'b1000, 0, 0);
    cycle();
    set_in(1, 32'hDEAD, 4'b1000, 0, 0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0);
    out_ready = 1'b1;
    cycle();
    chk("flush_empty", 64'(out_valid), 64'd0);
    repeat (2) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      cycle();
    end

    // Saturation then asynchronous reset mid-stall.
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1, 32'h55, 4'b1000, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    repeat (20) cycle();
    chk("sat_stall_cnt", 64'(stall_cnt), 64'(SAT));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 64'(stall_cnt), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    q.delete();
    m_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
      cycle();
    end
    set_in(0, 0, 0, 0, 0);
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
